// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: round-robin share of the VGA pixel port
// between box-drawing requesters and a full-screen clear.
module vga_plot_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int BOX_W           = 4,
  parameter int BOX_H           = 4,
  parameter int X_SCREEN_PIXELS = 160,
  parameter int Y_SCREEN_PIXELS = 120
) (
  input  logic                 iClock,
  input  logic                 iReset,
  input  logic [NUM_REQ-1:0]   iReq,
  input  logic [8*NUM_REQ-1:0] iX,
  input  logic [7*NUM_REQ-1:0] iY,
  input  logic [3*NUM_REQ-1:0] iColour,
  input  logic                 iClear,
  output logic [NUM_REQ-1:0]   oGrant,
  output logic                 oDone,
  output logic                 oBusy,
  output logic [7:0]           oX,
  output logic [6:0]           oY,
  output logic [2:0]           oColour,
  output logic                 oPlot
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [PW-1:0] REQ_LAST = PW'(NUM_REQ - 1);
  localparam logic [7:0]    BX_LAST  = 8'(BOX_W - 1);
  localparam logic [6:0]    BY_LAST  = 7'(BOX_H - 1);
  localparam logic [7:0]    CX_LAST  = 8'(X_SCREEN_PIXELS - 1);
  localparam logic [6:0]    CY_LAST  = 7'(Y_SCREEN_PIXELS - 1);
  localparam logic [8:0]    X_LIM    = 9'(X_SCREEN_PIXELS);
  localparam logic [7:0]    Y_LIM    = 8'(Y_SCREEN_PIXELS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BOX,
    S_CLEAR,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        win_q, win_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 pend_q, pend_d;
  logic [7:0]           px_q, px_d;
  logic [6:0]           py_q, py_d;
  logic [7:0]           x0_q, x0_d;
  logic [6:0]           y0_q, y0_d;
  logic [2:0]           col_q, col_d;

  logic [NUM_REQ-1:0]   o_grant_q, o_grant_d;
  logic                 o_done_q, o_done_d;
  logic                 o_busy_q, o_busy_d;
  logic [7:0]           o_x_q, o_x_d;
  logic [6:0]           o_y_q, o_y_d;
  logic [2:0]           o_col_q, o_col_d;
  logic                 o_plot_q, o_plot_d;

  logic [8:0]           sx;
  logic [7:0]           sy;
  logic                 found;
  logic [PW-1:0]        win_idx;
  logic [PW-1:0]        cand;

  // Round-robin search starting at the pointer, wrapping.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PW'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && iReq[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Next state, counters and registered pixel outputs.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    grant_d   = grant_q;
    pend_d    = pend_q;
    px_d      = px_q;
    py_d      = py_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    col_d     = col_q;
    o_x_d     = o_x_q;
    o_y_d     = o_y_q;
    o_col_d   = o_col_q;
    o_plot_d  = 1'b0;
    o_done_d  = 1'b0;
    o_busy_d  = (state_q != S_IDLE);
    o_grant_d = '0;
    sx = {1'b0, x0_q} + {1'b0, px_q};
    sy = {1'b0, y0_q} + {1'b0, py_q};

    unique case (state_q)
      S_IDLE: begin
        if (pend_q || iClear) begin
          state_d = S_CLEAR;
          pend_d  = 1'b0;
          grant_d = '0;
          px_d    = '0;
          py_d    = '0;
        end else if (found) begin
          state_d          = S_BOX;
          win_d            = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          x0_d             = iX[8*win_idx +: 8];
          y0_d             = iY[7*win_idx +: 7];
          col_d            = iColour[3*win_idx +: 3];
          px_d             = '0;
          py_d             = '0;
        end
      end
      S_BOX: begin
        if (iClear) pend_d = 1'b1;
        o_grant_d = grant_q;
        o_x_d     = sx[7:0];
        o_y_d     = sy[6:0];
        o_col_d   = col_q;
        o_plot_d  = (sx < X_LIM) && (sy < Y_LIM);
        if (px_q == BX_LAST) begin
          px_d = '0;
          if (py_q == BY_LAST) begin
            py_d    = '0;
            state_d = S_DONE;
          end else begin
            py_d = py_q + 7'd1;
          end
        end else begin
          px_d = px_q + 8'd1;
        end
      end
      S_CLEAR: begin
        if (iClear) pend_d = 1'b1;
        o_x_d    = px_q;
        o_y_d    = py_q;
        o_col_d  = 3'd0;
        o_plot_d = 1'b1;
        if (px_q == CX_LAST) begin
          px_d = '0;
          if (py_q == CY_LAST) begin
            py_d    = '0;
            state_d = S_DONE;
          end else begin
            py_d = py_q + 7'd1;
          end
        end else begin
          px_d = px_q + 8'd1;
        end
      end
      S_DONE: begin
        if (iClear) pend_d = 1'b1;
        o_done_d  = 1'b1;
        o_grant_d = grant_q;
        state_d   = S_IDLE;
        if (grant_q != '0) begin
          ptr_d = (win_q == REQ_LAST) ? '0 : win_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and output registers; reset aborts everything.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      grant_q   <= '0;
      pend_q    <= 1'b0;
      px_q      <= '0;
      py_q      <= '0;
      x0_q      <= '0;
      y0_q      <= '0;
      col_q     <= '0;
      o_grant_q <= '0;
      o_done_q  <= 1'b0;
      o_busy_q  <= 1'b0;
      o_x_q     <= '0;
      o_y_q     <= '0;
      o_col_q   <= '0;
      o_plot_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      grant_q   <= grant_d;
      pend_q    <= pend_d;
      px_q      <= px_d;
      py_q      <= py_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      col_q     <= col_d;
      o_grant_q <= o_grant_d;
      o_done_q  <= o_done_d;
      o_busy_q  <= o_busy_d;
      o_x_q     <= o_x_d;
      o_y_q     <= o_y_d;
      o_col_q   <= o_col_d;
      o_plot_q  <= o_plot_d;
    end
  end

  assign oGrant  = o_grant_q;
  assign oDone   = o_done_q;
  assign oBusy   = o_busy_q;
  assign oX      = o_x_q;
  assign oY      = o_y_q;
  assign oColour = o_col_q;
  assign oPlot   = o_plot_q;

endmodule
